servo_sweep_sched: RTL and testbench
====================================

Name: servo_sweep_sched

Overview:
Calibration and manual-move scheduler for the two-axis solar panel tracker. On a calibration request it sweeps the horizontal servo, then the vertical servo, across the full range, sampling panel voltage at each step. It records the maximum, then parks both servos at the best positions. Outside calibration it owns manual button jogging, and its position outputs feed the PWM generators for SERVO_H/SERVO_V.

Parameters:
POS_W, 32, width of servo pulse-width positions (clock counts)
ADC_W, 12, width of panel voltage sample
POS_MIN, 50000, lower pulse-width limit (0.5 ms @100 MHz)
POS_MAX, 250000, upper pulse-width limit (2.5 ms)
STEP, 10000, sweep increment per sample point
SETTLE, 2000000, cycles waited after each move before requesting a sample
MAN_STEP, 100, manual jog increment
MAN_DIV, 100000, cycles between manual jog steps while a button is held

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous, active-low reset
cal_start  in  1  one-cycle calibration request (debounced BTN_C)
man_l, man_r, man_u, man_d  in  1 each  manual jog requests (debounced, level)
sample_req  out  1  one-cycle request to ADC interface
adc_valid  in  1  sample-ready strobe
adc_data  in  ADC_W  panel voltage sample
pos_h  out  POS_W  horizontal servo pulse width
pos_v  out  POS_W  vertical servo pulse width
max_v  out  ADC_W  maximum voltage of last completed vertical sweep
busy  out  1  high from accepted cal_start until PARK exit
done  out  1  one-cycle pulse on calibration completion
state  out  3  current FSM state (debug/LCD)

Behaviour:
- Reset (async, RST_N=0): pos_h=pos_v=POS_CENTER=(POS_MIN+POS_MAX)/2; max_v=0; busy=0; done=0; sample_req=0; state=IDLE; all internal counters and best registers 0.
- States: IDLE=0, H_SETTLE=1, H_SAMPLE=2, V_SETTLE=3, V_SAMPLE=4, PARK=5.
- IDLE + cal_start: pos_h<=POS_MIN, run_max<=0, best_h<=POS_MIN, busy<=1, go to H_SETTLE. cal_start while busy is ignored.
- H_SETTLE: count SETTLE cycles from entry, then go to H_SAMPLE with sample_req=1 for exactly the first cycle.
- H_SAMPLE: wait for adc_valid. adc_valid outside *_SAMPLE is ignored. On adc_valid, if adc_data > run_max (strict; ties keep the earliest), then run_max<=adc_data and best_h<=pos_h.
  - If pos_h+STEP > POS_MAX: pos_h<=best_h, pos_v<=POS_MIN, run_max<=0, best_v<=POS_MIN, go to V_SETTLE.
  - Otherwise: pos_h<=pos_h+STEP, go to H_SETTLE.
- V_SETTLE/V_SAMPLE: identical sequence on pos_v/best_v. At the end: pos_v<=best_v, max_v<=run_max, go to PARK.
- PARK: one cycle; done=1, busy<=0, next state IDLE.
- Compute pos+STEP at POS_W+1 bits; no wrap. The last sample point is the largest POS_MIN+k*STEP ≤ POS_MAX.
- Manual jogging, IDLE only:
  - A free-running divider is cleared while no button is held. On each MAN_DIV terminal count: man_r adds MAN_STEP to pos_h, man_l subtracts it; man_u/man_d act the same on pos_v.
  - Results saturate at POS_MAX/POS_MIN.
  - l+r both held: no H motion. u+d both held: no V motion. H and V may move in the same step.
- Manual inputs are ignored in all non-IDLE states. cal_start takes priority over a jog step in the same cycle.
- Reset mid-sweep returns all outputs to reset values immediately. No partial results are retained.

Optional Feature:
SWEEP_ABORT_EN:
- When defined, cal_start is sampled at entry to calibration and pos_h/pos_v are saved. Any manual button asserted in a non-IDLE, non-PARK state aborts the sweep:
  - pos_h/pos_v are restored to the saved values next cycle.
  - state=IDLE, busy=0, no done pulse, max_v unchanged.
- When undefined, manual buttons never affect a running sweep and no save registers exist.

Test Plan:
- Bench parameters for all scenarios: POS_MIN=0, POS_MAX=40, STEP=10, SETTLE=4, MAN_STEP=5, MAN_DIV=2.
- Reset: RST_N=0 -> pos_h=pos_v=20, busy=0, done=0, state=0; release, idle 20 cycles -> unchanged.
- Full calibration: cal_start; ADC model answers sample_req after 3 cycles. H samples {100,300,700,200,50}, V samples {10,900,900,20,5} -> five sample_req per axis, each ≥4 cycles after a move. Final pos_h=20, pos_v=10 (tie keeps first), max_v=900, one-cycle done, busy low after.
- Manual: hold man_r from pos_h=20 -> 25,30,...,40, saturates at 40. Hold man_l+man_r -> pos_h unchanged. Hold man_u+man_l -> pos_v+5 and pos_h-5 in the same step.
- Ignored inputs: cal_start pulse and man_d mid-sweep -> no restart, pos_v unaffected, done count=1. Stray adc_valid in H_SETTLE -> run_max unchanged.
- Async reset in V_SAMPLE -> outputs return to reset values before the next CLK edge. A new cal_start then completes normally.
- SWEEP_ABORT_EN: start at pos_h=pos_v=20, press man_l during H_SETTLE -> pos_h=pos_v=20 next cycle, state=0, done never pulses, max_v keeps its previous value.

Source files
------------

// File: rtl/servo_sweep_sched.sv
// Two-axis sweep calibration and manual jog scheduler for the solar tracker servos.
// Optional build macro SWEEP_ABORT_EN: a manual button pressed mid-sweep aborts and restores the saved positions.
module servo_sweep_sched #(
  parameter int unsigned POS_W    = 32'd32,
  parameter int unsigned ADC_W    = 32'd12,
  parameter int unsigned POS_MIN  = 32'd50000,
  parameter int unsigned POS_MAX  = 32'd250000,
  parameter int unsigned STEP     = 32'd10000,
  parameter int unsigned SETTLE   = 32'd2000000,
  parameter int unsigned MAN_STEP = 32'd100,
  parameter int unsigned MAN_DIV  = 32'd100000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cal_start,
  input  logic             man_l,
  input  logic             man_r,
  input  logic             man_u,
  input  logic             man_d,
  output logic             sample_req,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic [POS_W-1:0] pos_h,
  output logic [POS_W-1:0] pos_v,
  output logic [ADC_W-1:0] max_v,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_H_SETTLE = 3'd1,
    ST_H_SAMPLE = 3'd2,
    ST_V_SETTLE = 3'd3,
    ST_V_SAMPLE = 3'd4,
    ST_PARK     = 3'd5
  } state_t;

  localparam logic [POS_W:0]   MIN_X      = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0]   MAX_X      = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   STEP_X     = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   MSTEP_X    = (POS_W+1)'(MAN_STEP);
  localparam logic [POS_W-1:0] MIN_P      = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_P      = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_CENTER = POS_W'((POS_MIN + POS_MAX) / 32'd2);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE - 32'd1);
  localparam logic [31:0]      DIV_LAST    = 32'(MAN_DIV - 32'd1);

  // Saturating manual jog; opposing buttons cancel.
  function automatic logic [POS_W-1:0] jog_pos(input logic [POS_W-1:0] pos,
                                               input logic up, input logic dn);
    logic [POS_W:0] wide;
    wide = {1'b0, pos};
    if (up && !dn) begin
      if ((wide + MSTEP_X) > MAX_X) jog_pos = MAX_P;
      else                          jog_pos = POS_W'(wide + MSTEP_X);
    end else if (dn && !up) begin
      if (wide < (MIN_X + MSTEP_X)) jog_pos = MIN_P;
      else                          jog_pos = POS_W'(wide - MSTEP_X);
    end else begin
      jog_pos = pos;
    end
  endfunction

  state_t             state_r, state_nxt_s, state_seq_s;
  logic [POS_W-1:0]   pos_h_r, pos_v_r, best_h_r, best_v_r;
  logic [ADC_W-1:0]   run_max_r, max_v_r;
  logic [31:0]        settle_cnt_r, div_cnt_r;
  logic               busy_r, done_r, sample_req_r;

  logic [POS_W-1:0]   axis_pos_s, axis_best_s, best_eff_s;
  logic [POS_W:0]     step_sum_s;
  logic [ADC_W-1:0]   max_eff_s;
  logic               last_pt_s, settle_done_s, new_max_s, any_man_s, jog_tick_s, abort_s;

`ifdef SWEEP_ABORT_EN
  logic [POS_W-1:0]   save_h_r, save_v_r;
`endif

  // Sweep arithmetic shared by both axes.
  always_comb begin
    axis_pos_s  = pos_h_r;
    axis_best_s = best_h_r;
    if (state_r == ST_V_SETTLE || state_r == ST_V_SAMPLE) begin
      axis_pos_s  = pos_v_r;
      axis_best_s = best_v_r;
    end else begin
      axis_pos_s  = pos_h_r;
      axis_best_s = best_h_r;
    end
    step_sum_s    = {1'b0, axis_pos_s} + STEP_X;
    last_pt_s     = (step_sum_s > MAX_X);
    settle_done_s = (settle_cnt_r == SETTLE_LAST);
    new_max_s     = (adc_data > run_max_r);
    best_eff_s    = new_max_s ? axis_pos_s : axis_best_s;
    max_eff_s     = new_max_s ? adc_data : run_max_r;
    any_man_s     = man_l | man_r | man_u | man_d;
    jog_tick_s    = (state_r == ST_IDLE) && any_man_s && (div_cnt_r == DIV_LAST);
`ifdef SWEEP_ABORT_EN
    abort_s       = any_man_s && (state_r != ST_IDLE) && (state_r != ST_PARK);
`else
    abort_s       = 1'b0;
`endif
  end

  // Next-state decode.
  always_comb begin
    state_seq_s = state_r;
    case (state_r)
      ST_IDLE:     state_seq_s = cal_start ? ST_H_SETTLE : ST_IDLE;
      ST_H_SETTLE: state_seq_s = settle_done_s ? ST_H_SAMPLE : ST_H_SETTLE;
      ST_H_SAMPLE: begin
        if (adc_valid) state_seq_s = last_pt_s ? ST_V_SETTLE : ST_H_SETTLE;
        else           state_seq_s = ST_H_SAMPLE;
      end
      ST_V_SETTLE: state_seq_s = settle_done_s ? ST_V_SAMPLE : ST_V_SETTLE;
      ST_V_SAMPLE: begin
        if (adc_valid) state_seq_s = last_pt_s ? ST_PARK : ST_V_SETTLE;
        else           state_seq_s = ST_V_SAMPLE;
      end
      ST_PARK:     state_seq_s = ST_IDLE;
      default:     state_seq_s = ST_IDLE;
    endcase
    if (abort_s) state_nxt_s = ST_IDLE;
    else         state_nxt_s = state_seq_s;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

`ifdef SWEEP_ABORT_EN
  // Positions captured at calibration entry, restored on abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      save_h_r <= '0;
      save_v_r <= '0;
    end else if (state_r == ST_IDLE && cal_start) begin
      save_h_r <= pos_h_r;
      save_v_r <= pos_v_r;
    end
  end
`endif

  // Datapath: counters, positions, running maximum and strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pos_h_r      <= POS_CENTER;
      pos_v_r      <= POS_CENTER;
      best_h_r     <= '0;
      best_v_r     <= '0;
      run_max_r    <= '0;
      max_v_r      <= '0;
      settle_cnt_r <= 32'd0;
      div_cnt_r    <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sample_req_r <= 1'b0;
    end else begin
      sample_req_r <= 1'b0;
      done_r       <= 1'b0;

      if ((state_r == ST_H_SETTLE || state_r == ST_V_SETTLE) && !settle_done_s)
        settle_cnt_r <= settle_cnt_r + 32'd1;
      else
        settle_cnt_r <= 32'd0;

      if (state_r == ST_IDLE && any_man_s && !jog_tick_s)
        div_cnt_r <= div_cnt_r + 32'd1;
      else
        div_cnt_r <= 32'd0;

      case (state_r)
        ST_IDLE: begin
          if (cal_start) begin
            pos_h_r   <= MIN_P;
            run_max_r <= '0;
            best_h_r  <= MIN_P;
            busy_r    <= 1'b1;
          end else if (jog_tick_s) begin
            pos_h_r <= jog_pos(pos_h_r, man_r, man_l);
            pos_v_r <= jog_pos(pos_v_r, man_u, man_d);
          end
        end
        ST_H_SETTLE, ST_V_SETTLE: begin
          if (settle_done_s) sample_req_r <= 1'b1;
        end
        ST_H_SAMPLE: begin
          if (adc_valid) begin
            if (new_max_s) begin
              run_max_r <= adc_data;
              best_h_r  <= pos_h_r;
            end
            if (last_pt_s) begin
              pos_h_r   <= best_eff_s;
              pos_v_r   <= MIN_P;
              run_max_r <= '0;
              best_v_r  <= MIN_P;
            end else begin
              pos_h_r <= step_sum_s[POS_W-1:0];
            end
          end
        end
        ST_V_SAMPLE: begin
          if (adc_valid) begin
            if (new_max_s) begin
              run_max_r <= adc_data;
              best_v_r  <= pos_v_r;
            end
            if (last_pt_s) begin
              pos_v_r <= best_eff_s;
              max_v_r <= max_eff_s;
              done_r  <= 1'b1;
            end else begin
              pos_v_r <= step_sum_s[POS_W-1:0];
            end
          end
        end
        ST_PARK: busy_r <= 1'b0;
        default: busy_r <= 1'b0;
      endcase

`ifdef SWEEP_ABORT_EN
      if (abort_s) begin
        pos_h_r      <= save_h_r;
        pos_v_r      <= save_v_r;
        busy_r       <= 1'b0;
        done_r       <= 1'b0;
        sample_req_r <= 1'b0;
      end
`endif
    end
  end

  assign pos_h      = pos_h_r;
  assign pos_v      = pos_v_r;
  assign max_v      = max_v_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sample_req = sample_req_r;
  assign state      = state_r;

endmodule

// File: tb/tb_servo_sweep_sched.sv
// Directed bench for servo_sweep_sched: reset, full calibration, jog table, ignored inputs,
// async reset mid-sweep and (with SWEEP_ABORT_EN) sweep abort.
module tb_servo_sweep_sched;

  localparam int SETTLE = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cal_start = 1'b0;
  logic        man_l = 1'b0, man_r = 1'b0, man_u = 1'b0, man_d = 1'b0;
  logic        sample_req;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic [31:0] pos_h, pos_v;
  logic [11:0] max_v;
  logic        busy, done;
  logic [2:0]  state;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;

  logic [11:0] h_dat [5] = '{12'd100, 12'd300, 12'd700, 12'd200, 12'd50};
  logic [11:0] v_dat [5] = '{12'd10, 12'd900, 12'd900, 12'd20, 12'd5};

  typedef struct {
    logic        l, r, u, d;
    logic [31:0] exp_h, exp_v;
  } jog_vec_t;

  servo_sweep_sched #(
    .POS_W(32), .ADC_W(12), .POS_MIN(0), .POS_MAX(40), .STEP(10),
    .SETTLE(SETTLE), .MAN_STEP(5), .MAN_DIV(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .cal_start(cal_start),
    .man_l(man_l), .man_r(man_r), .man_u(man_u), .man_d(man_d),
    .sample_req(sample_req), .adc_valid(adc_valid), .adc_data(adc_data),
    .pos_h(pos_h), .pos_v(pos_v), .max_v(max_v),
    .busy(busy), .done(done), .state(state)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %0d required %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos_h"}, pos_h, 20);
    chk({tag, "_pos_v"}, pos_v, 20);
    chk({tag, "_max_v"}, max_v, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_sample_req"}, sample_req, 0);
  endtask

  // Hold buttons for two clocks (one MAN_DIV period), release, then check.
  task automatic jog_step(input jog_vec_t v, input int idx);
    man_l = v.l; man_r = v.r; man_u = v.u; man_d = v.d;
    @(negedge CLK); @(negedge CLK);
    man_l = 1'b0; man_r = 1'b0; man_u = 1'b0; man_d = 1'b0;
    @(negedge CLK);
    chk($sformatf("jog%0d_pos_h", idx), pos_h, v.exp_h);
    chk($sformatf("jog%0d_pos_v", idx), pos_v, v.exp_v);
  endtask

  // Calibration run with an ADC model answering 3 cycles after each sample_req.
  task automatic run_cal(input bit inject, input bit rst_mid);
    int gap;
    bit seen;
    int done0;
    logic [31:0] pv0;
    done0 = done_cnt;
    pv0 = pos_v;
    cal_start = 1'b1;
    @(negedge CLK);
    cal_start = 1'b0;
    gap = 1;
    chk("start_busy", busy, 1);
    chk("start_state", state, 1);
    chk("start_pos_h", pos_h, 0);
    for (int s = 0; s < 10; s++) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (sample_req) begin
          seen = 1'b1;
        end else begin
          if (inject) begin
            adc_valid = (s == 0 && c == 1);
            adc_data  = 12'hFFF;
            cal_start = (s == 3 && c == 1);
            man_d     = (s >= 2 && s < 5);
          end
          @(negedge CLK);
          gap++;
        end
      end
      if (!seen) begin
        chk($sformatf("sample_req_timeout_%0d", s), 0, 1);
        return;
      end
      chk($sformatf("settle_gap_%0d", s), gap, SETTLE + 1);
      chk($sformatf("sample_state_%0d", s), state, (s < 5) ? 2 : 4);
      chk($sformatf("busy_mid_%0d", s), busy, 1);
      if (inject && s >= 2 && s < 5) chk($sformatf("pos_v_held_%0d", s), pos_v, pv0);
      if (s == 5) chk("pos_h_parked", pos_h, 20);
      if (rst_mid && s == 5) begin
        #2 RST_N = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        return;
      end
      @(negedge CLK);
      chk($sformatf("req_one_cycle_%0d", s), sample_req, 0);
      @(negedge CLK);
      @(negedge CLK);
      adc_valid = 1'b1;
      adc_data  = (s < 5) ? h_dat[s] : v_dat[s-5];
      @(negedge CLK);
      adc_valid = 1'b0;
      gap = 1;
    end
    chk("park_state", state, 5);
    chk("park_done", done, 1);
    @(negedge CLK);
    chk("end_done", done, 0);
    chk("end_busy", busy, 0);
    chk("end_state", state, 0);
    chk("end_pos_h", pos_h, 20);
    chk("end_pos_v", pos_v, 10);
    chk("end_max_v", max_v, 900);
    chk("done_count", done_cnt - done0, 1);
  endtask

  jog_vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd25, 32'd10};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd30, 32'd10};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd35, 32'd10};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd40, 32'd10};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd40, 32'd10};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd40, 32'd10};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd35, 32'd15};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd35, 32'd10};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd35, 32'd5};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd35, 32'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd35, 32'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd35, 32'd5};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd35, 32'd5};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd30, 32'd5};

    @(negedge CLK);
    @(negedge CLK);
    chk_reset_vals("reset");
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk_reset_vals("idle20");

    run_cal(1'b0, 1'b0);

    for (int i = 0; i < 14; i++) jog_step(tbl[i], i);

`ifdef SWEEP_ABORT_EN
    run_cal(1'b0, 1'b0);
`else
    run_cal(1'b1, 1'b0);
`endif
    man_d = 1'b0;
    cal_start = 1'b0;
    adc_valid = 1'b0;
    repeat (3) @(negedge CLK);

    run_cal(1'b0, 1'b1);
    run_cal(1'b0, 1'b0);

    jog_step('{1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'd15}, 20);
    jog_step('{1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'd20}, 21);

`ifdef SWEEP_ABORT_EN
    begin
      int d0;
      d0 = done_cnt;
      cal_start = 1'b1;
      @(negedge CLK);
      cal_start = 1'b0;
      @(negedge CLK);
      chk("abort_pre_pos_h", pos_h, 0);
      man_l = 1'b1;
      @(negedge CLK);
      man_l = 1'b0;
      chk("abort_state", state, 0);
      chk("abort_pos_h", pos_h, 20);
      chk("abort_pos_v", pos_v, 20);
      chk("abort_busy", busy, 0);
      chk("abort_max_v", max_v, 900);
      repeat (10) @(negedge CLK);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle_state", state, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
